la_scanctrl: RTL



---
 rtl/la_scanctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/la_scanctrl.sv
// -----------------------------------------------------------------------------
// la_scanctrl
//
// Scan-chain shift/capture controller. A pattern word arrives on the input
// handshake and is shifted into a chain of LEN scan flops, bit 0 first, via
// se/si. At the same time, the chain's previous contents are collected from so.
// An optional single capture cycle (se=0) then lets the chain load functional
// data. The collected response word is presented on the output handshake.
//
// Parameters
//   LEN    scan chain length and pattern/response width (LEN >= 2)
//   SOINV  1 = invert every sampled so bit (odd number of inverting cells)
//   PROP   implementation property string, no functional effect
//
// Ports
//   clk, nreset        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  pattern handshake; in_data = pattern, in_capture = capture request
//   se, si, so         scan enable, scan in (first flop), scan out (last flop)
//   out_valid/out_ready response handshake; out_data = response, bit 0 sampled first
//   busy               high whenever the controller is not idle
// -----------------------------------------------------------------------------
module la_scanctrl #(
  parameter int    LEN   = 8,
  parameter bit    SOINV = 1'b0,
  parameter string PROP  = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_data,
  input  logic           in_capture,
  output logic           se,
  output logic           si,
  input  logic           so,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_data,
  output logic           busy
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  pat_q, pat_d;
  logic [LEN-1:0]  resp_q, resp_d;
  logic            cap_q, cap_d;
  logic            se_q, se_d;
  logic            si_q, si_d;
  logic            out_valid_q, out_valid_d;

  // State and datapath registers. se/si are registered so that the chain sees
  // each pattern bit for a full cycle, and nothing reaches an output
  // combinationally from so or the ready inputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pat_q       <= '0;
      resp_q      <= '0;
      cap_q       <= 1'b0;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      resp_q      <= resp_d;
      cap_q       <= cap_d;
      se_q        <= se_d;
      si_q        <= si_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath logic. The registered se/si values are computed
  // one cycle ahead. The cycle that enters SHIFT already presents bit 0, and
  // each SHIFT cycle presents the next pattern bit. The pattern register shifts
  // right, so the upcoming bit always sits at pat_q[1]. The response register
  // fills from the top, so the first sampled bit ends up at bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    resp_d      = resp_q;
    cap_d       = cap_q;
    se_d        = se_q;
    si_d        = si_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pat_d   = in_data;
          cap_d   = in_capture;
          cnt_d   = '0;
          se_d    = 1'b1;
          si_d    = in_data[0];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        resp_d = {so ^ SOINV, resp_q[LEN-1:1]};
        pat_d  = pat_q >> 1;
        if (cnt_q == LAST) begin
          se_d = 1'b0;
          si_d = 1'b0;
          if (cap_q) begin
            state_d = CAPTURE;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          si_d  = pat_q[1];
        end
      end

      // se is already low here, so the chain loads its functional data on
      // this edge.
      CAPTURE: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign se        = se_q;
  assign si        = si_q;
  assign out_valid = out_valid_q;
  assign out_data  = resp_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule
